// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the 16-by-8 sequential divider.
// Holds the controller state encoding, the default operand widths and the
// quotient value reported when the divisor is zero.
package seq_div_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;
    localparam int CNT_W_DEF      = 5;

    // Quotient reported for a divide-by-zero request (all ones).
    localparam logic [DIVIDEND_W_DEF-1:0] DBZ_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, purely combinational.
// The incoming partial remainder is shifted left by one and takes the next
// dividend bit. If the divisor fits, it is subtracted and the quotient bit is 1.
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W-1:0] prem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] prem_o,
    output logic                 qbit_o
);

    logic [DIVISOR_W:0] trial;

    // Trial subtraction on the 9-bit shifted value. The difference always fits
    // in DIVISOR_W bits, so the subtraction is done on the low bits only.
    always_comb begin
        trial  = {prem_i, bit_i};
        prem_o = trial[DIVISOR_W-1:0];
        qbit_o = 1'b0;
        if (trial >= {1'b0, divisor_i}) begin
            prem_o = trial[DIVISOR_W-1:0] - divisor_i;
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: sequential 16-by-8 restoring divider, one step per clock.
// A start in IDLE captures the operands, CALC runs sixteen steps through
// div_step, and DONE raises a one-cycle done pulse with registered results.
// Define SEQ_DIV_SIGNED_EN to treat operands as two's complement (the core
// still divides magnitudes; signs are fixed up when the result is loaded).
module seq_divider_16by8
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_a,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done_flag,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    div_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVIDEND_W-1:0] dq_q;
    logic [DIVISOR_W-1:0]  prem_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  dbz_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DIVIDEND_W-1:0] dq_d;
    logic [DIVISOR_W-1:0]  prem_d;
    logic                  qbit;
    logic [DIVIDEND_W-1:0] dividendAbs;
    logic [DIVISOR_W-1:0]  divisorAbs;
    logic [DIVIDEND_W-1:0] resQuot;
    logic [DIVISOR_W-1:0]  resRem;

`ifdef SEQ_DIV_SIGNED_EN
    logic negQuot_q;
    logic negRem_q;
`endif

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .prem_i    (prem_q),
        .bit_i     (dq_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .prem_o    (prem_d),
        .qbit_o    (qbit)
    );

`ifdef SEQ_DIV_SIGNED_EN
    // Operand magnitudes. The most negative values negate to themselves, which
    // read as unsigned are exactly their magnitudes (32768 and 128).
    always_comb begin
        dividendAbs = dividend;
        divisorAbs  = divisor;
        if (dividend[DIVIDEND_W-1]) begin
            dividendAbs = ~dividend + DIVIDEND_W'(1);
        end
        if (divisor[DIVISOR_W-1]) begin
            divisorAbs = ~divisor + DIVISOR_W'(1);
        end
    end
`else
    // Unsigned build: operands go straight into the core.
    always_comb begin
        dividendAbs = dividend;
        divisorAbs  = divisor;
    end
`endif

    // Next shift-register value and the final results formed on the last step.
    always_comb begin
        dq_d    = {dq_q[DIVIDEND_W-2:0], qbit};
        resQuot = dq_d;
        resRem  = prem_d;
`ifdef SEQ_DIV_SIGNED_EN
        if (negQuot_q) begin
            resQuot = ~dq_d + DIVIDEND_W'(1);
        end
        if (negRem_q) begin
            resRem = ~prem_d + DIVISOR_W'(1);
        end
`endif
    end

    // Controller FSM with registered outputs. The divide-by-zero path spends an
    // extra silent cycle in DONE so its done pulse lands two cycles after accept.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            negQuot_q   <= 1'b0;
            negRem_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            quotient_q  <= DIVIDEND_W'(DBZ_QUOTIENT);
                            remainder_q <= dividend[DIVISOR_W-1:0];
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            dq_q    <= dividendAbs;
                            dvs_q   <= divisorAbs;
                            prem_q  <= '0;
                            cnt_q   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                            negQuot_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                            negRem_q  <= dividend[DIVIDEND_W-1];
`endif
                        end
                    end
                end
                CALC: begin
                    dq_q   <= dq_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                        state_q     <= DONE;
                        quotient_q  <= resQuot;
                        remainder_q <= resRem;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done_flag   = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
